tmds_channel_decoder: RTL
=========================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS encoder used by the HDMI test transmitter.
- Takes one deserialized 10-bit TMDS word per pixel clock for one channel (R, G or B).
- Word alignment is controlled by issuing bitslip pulses to the external deserializer until control-token runs are found.
- Once locked, it decodes each word back to 8-bit video data (VD), 2-bit control data (CD) and the video-data-enable flag (VDE).

Parameters:
- CTRL_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 2048: cycles without any control token before a bitslip (SEARCH) or loss of lock (LOCKED). Range 2..65535.
- SLIP_WAIT, 4: cycles to ignore input after each bitslip pulse. Range 1..15.

Ports:
- clk  in  1  pixel clock (25 MHz); all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- tmds_in  in  10  deserialized word; bit 0 is the first bit on the wire.
- bitslip  out  1  single-cycle request to the deserializer to shift word alignment by one bit.
- locked  out  1  alignment achieved.
- vd  out  8  decoded video data.
- cd  out  2  decoded control data; for the blue channel, cd[0]=hsync and cd[1]=vsync.
- vde  out  1  1 = data period, 0 = control period.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - bitslip=0, locked=0, vd=0, cd=0, vde=0.
  - All counters cleared; FSM enters SEARCH.
  - rst asserted mid-operation (including during WAIT) aborts immediately and takes effect on the next edge.
- Control token classification (combinational on tmds_in):
  - 10'b1101010100 -> cd=00
  - 10'b0010101011 -> cd=01
  - 10'b0101010100 -> cd=10
  - 10'b1010101011 -> cd=11
  - Any other word is a data word.
- Data decode:
  - q = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0].
  - d[0] = q[0].
  - For i=1..7: d[i] = tmds_in[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Output timing (latency 1 cycle; outputs are registered from the tmds_in sampled on the previous edge):
  - Control token while locked: vde=0, cd=token value, vd=0.
  - Data word while locked: vde=1, vd=d, cd holds its last control value.
  - Whenever locked=0: vde=0, vd=0, cd=0.
- Counters:
  - run_cnt counts consecutive control tokens. It clears on any data word and saturates at CTRL_RUN.
  - idle_cnt counts cycles since the last control token. It clears on any control token and saturates at SEARCH_TIMEOUT.
- FSM states: SEARCH, SLIP, WAIT, LOCKED.
  - SEARCH -> LOCKED when run_cnt reaches CTRL_RUN. The word completing the run is the first word decoded with locked=1; locked rises with the same latency as the data outputs.
  - SEARCH -> SLIP when idle_cnt reaches SEARCH_TIMEOUT.
  - SLIP: bitslip=1 for exactly one cycle, then -> WAIT. Both counters clear.
  - WAIT: input ignored and counters held at 0 for SLIP_WAIT cycles, then -> SEARCH.
  - LOCKED -> SEARCH when idle_cnt reaches SEARCH_TIMEOUT. locked drops on the next edge; no bitslip is issued on this transition.
  - If the run completes on the same cycle idle_cnt hits the timeout, the LOCKED transition wins.
- Bitslip spacing: at most one bitslip pulse per SEARCH_TIMEOUT+SLIP_WAIT+1 cycles. bitslip is never asserted in LOCKED.

Test Plan:
- Lock acquisition:
  - Stimulus: reset, then 8 consecutive 10'b1101010100.
  - Required: locked=1 with cd=00, vde=0 one cycle after the 8th token is sampled; bitslip never pulses.
- Data decode:
  - Stimulus: once locked, apply 10'h100, then 10'h1FF, then 10'b0010101011.
  - Required: vd=8'h00/vde=1, then vd=8'h01/vde=1, then vde=0/cd=01, each 1 cycle after input.
- Search timeout:
  - Stimulus: reset, drive constant 10'h155 (a data word).
  - Required: bitslip pulses 1 cycle wide at cycle 2048 after reset, then again every 2048+4+1 cycles; locked stays 0.
- Run broken:
  - Stimulus: 7 tokens, 1 data word, 8 tokens.
  - Required: lock only after the second run completes; vde=0 and vd=0 before lock.
- Loss of lock:
  - Stimulus: lock, then 2048 data words with no control token.
  - Required: locked falls at the timeout, outputs go to 0, no bitslip pulse; re-lock after 8 tokens.
- Reset during WAIT:
  - Stimulus: assert rst 2 cycles after a bitslip pulse.
  - Required: all outputs 0 on the next edge; the next bitslip does not occur before 2048 cycles have elapsed.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: aligns one deserialized TMDS channel via bitslip on control-token runs, then decodes VD/CD/VDE.
// Ports: clk, rst (sync, active-high); tmds_in[9:0] word, bit 0 first on the wire;
//        bitslip one-cycle realign request; locked alignment found; vd[7:0] video data;
//        cd[1:0] control data; vde data-period flag. All outputs registered, latency 1.
module tmds_channel_decoder #(
    parameter int CTRL_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde
);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int IW = $clog2(SEARCH_TIMEOUT + 1);
    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;
    state_t        state_q, state_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic [IW-1:0] idle_q, idle_d, idle_inc;
    logic [3:0]    wait_q, wait_d;
    logic          bitslip_q, bitslip_d, locked_q, locked_d, vde_q, vde_d, is_ctrl;
    logic [7:0]    vd_q, vd_d, q, d;
    logic [1:0]    cd_q, cd_d, tok;
    assign is_ctrl = tmds_in inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    assign tok = (tmds_in == 10'b0010101011) ? 2'b01 :
                 (tmds_in == 10'b0101010100) ? 2'b10 :
                 (tmds_in == 10'b1010101011) ? 2'b11 : 2'b00;
    assign q = tmds_in[9] ? ~tmds_in[7:0] : tmds_in[7:0];
    // bit 8 selects XOR vs XNOR chaining
    assign d = {q[7:1] ^ q[6:0] ^ {7{~tmds_in[8]}}, q[0]};
    assign run_inc  = is_ctrl ? ((run_q == RW'(CTRL_RUN)) ? run_q : run_q + RW'(1)) : '0;
    assign idle_inc = is_ctrl ? '0 : ((idle_q == IW'(SEARCH_TIMEOUT)) ? idle_q : idle_q + IW'(1));
    always_comb begin
        state_d = state_q;
        run_d   = run_inc;
        idle_d  = idle_inc;
        wait_d  = '0;
        case (state_q)
            SEARCH: state_d = (run_inc == RW'(CTRL_RUN)) ? LOCKED :
                              (idle_inc == IW'(SEARCH_TIMEOUT)) ? SLIP : SEARCH;
            SLIP: begin
                state_d = WAIT;
                run_d   = '0;
                idle_d  = '0;
            end
            WAIT: begin
                run_d   = '0;
                idle_d  = '0;
                wait_d  = wait_q + 4'd1;
                state_d = (wait_q == 4'(SLIP_WAIT - 1)) ? SEARCH : WAIT;
            end
            default: if (idle_inc == IW'(SEARCH_TIMEOUT)) begin
                // lock lost: restart search with fresh counters, no slip yet
                state_d = SEARCH;
                run_d   = '0;
                idle_d  = '0;
            end
        endcase
        bitslip_d = state_d == SLIP;
        locked_d  = state_d == LOCKED;
        vde_d     = locked_d && !is_ctrl;
        vd_d      = vde_d ? d : 8'h00;
        cd_d      = !locked_d ? 2'b00 : is_ctrl ? tok : cd_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            run_q     <= '0;
            idle_q    <= '0;
            wait_q    <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            vde_q     <= 1'b0;
            vd_q      <= '0;
            cd_q      <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            idle_q    <= idle_d;
            wait_q    <= wait_d;
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            vde_q     <= vde_d;
            vd_q      <= vd_d;
            cd_q      <= cd_d;
        end
    end
    assign bitslip = bitslip_q;
    assign locked  = locked_q;
    assign vde     = vde_q;
    assign vd      = vd_q;
    assign cd      = cd_q;
endmodule
